// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle control sequencer for the LEGv8 shared-ALU/shared-memory datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, and faults on stalled memory handshakes.
module legv8_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        IMemReady,
  input  logic        DMemReady,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [1:0]  SignOp,
  output logic        ALUSrc,
  output logic [1:0]  ALUOp,
  output logic        Reg2Loc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        Illegal,
  output logic        Fault
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LDUR, C_STUR, C_RTYPE, C_ITYPE, C_CBZ, C_B
  } cls_t;

  localparam logic [15:0] WAIT_MAX = 16'(WAIT_LIMIT);

  state_t      state, state_d;
  cls_t        cls, cls_d;
  logic [15:0] wait_cnt, wait_cnt_d, wait_inc;
  logic        fault, fault_d;

  cls_t        dec_cls;
  logic        dec_ok;
  logic        drive_cls;
  logic        waiting;

  assign wait_inc = wait_cnt + 16'd1;

  // Opcode is only meaningful in DECODE; everything later uses the latched class.
  always_comb begin
    dec_cls = C_LDUR;
    dec_ok  = 1'b1;
    casez (Opcode)
      11'b11111000010: dec_cls = C_LDUR;
      11'b11111000000: dec_cls = C_STUR;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_cls = C_RTYPE;
      11'b1001000100?,
      11'b1101000100?: dec_cls = C_ITYPE;
      11'b10110100???: dec_cls = C_CBZ;
      11'b000101?????: dec_cls = C_B;
      default:         dec_ok  = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= S_FETCH;
      cls      <= C_LDUR;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= state_d;
      cls      <= cls_d;
      wait_cnt <= wait_cnt_d;
      fault    <= fault_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d    = state;
    cls_d      = cls;
    wait_cnt_d = '0;
    fault_d    = fault;
    drive_cls  = 1'b0;
    waiting    = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    SignOp     = 2'b00;
    ALUSrc     = 1'b0;
    ALUOp      = 2'b00;
    Reg2Loc    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    Illegal    = 1'b0;

    case (state)
      S_FETCH: begin
        if (IMemReady) begin
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end else begin
          Illegal = 1'b1;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        drive_cls = 1'b1;
        case (cls)
          C_B: begin
            PCWrite = 1'b1;
            PCSrc   = 1'b1;
            state_d = S_FETCH;
          end
          C_CBZ: begin
            PCWrite = 1'b1;
            PCSrc   = Zero;
            state_d = S_FETCH;
          end
          C_LDUR, C_STUR: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        drive_cls = 1'b1;
        MemRead   = (cls == C_LDUR);
        MemWrite  = (cls == C_STUR);
        if (DMemReady) begin
          if (cls == C_STUR) begin
            PCWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB: begin
        drive_cls = 1'b1;
        RegWrite  = 1'b1;
        MemToReg  = (cls == C_LDUR);
        PCWrite   = 1'b1;
        state_d   = S_FETCH;
      end
      default: ;
    endcase

    // A ready in the cycle the count would reach the limit never gets here.
    if (waiting) begin
      if (wait_inc == WAIT_MAX) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end else begin
        wait_cnt_d = wait_inc;
      end
    end

    if (drive_cls) begin
      ALUSrc  = (cls == C_LDUR) || (cls == C_STUR) || (cls == C_ITYPE);
      Reg2Loc = (cls == C_STUR) || (cls == C_CBZ);
      case (cls)
        C_ITYPE: SignOp = 2'b01;
        C_CBZ:   SignOp = 2'b10;
        C_B:     SignOp = 2'b11;
        default: SignOp = 2'b00;
      endcase
      case (cls)
        C_CBZ:            ALUOp = 2'b01;
        C_RTYPE, C_ITYPE: ALUOp = 2'b10;
        default:          ALUOp = 2'b00;
      endcase
    end

    // Reset masks every strobe in the same cycle so no partial write escapes.
    if (Reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 1'b0;
      SignOp   = 2'b00;
      ALUSrc   = 1'b0;
      ALUOp    = 2'b00;
      Reg2Loc  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemToReg = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

  assign Fault = fault & ~Reset;

endmodule
